// File: rtl/cl_pcim_arb.sv
// Two-requester AXI arbiter onto the shared PCIM master port.
// AW and AR each have a round-robin grant FSM. W follows AW order through a small FIFO.
// B and R are routed back to a requester by id bit 9.
module cl_pcim_arb #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned WORD_FIFO_DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  // requester 0
  input  logic         s0_awvalid_i,
  output logic         s0_awready_o,
  input  logic [8:0]   s0_awid_i,
  input  logic [63:0]  s0_awaddr_i,
  input  logic [7:0]   s0_awlen_i,
  input  logic         s0_wvalid_i,
  output logic         s0_wready_o,
  input  logic [511:0] s0_wdata_i,
  input  logic [63:0]  s0_wstrb_i,
  input  logic         s0_wlast_i,
  output logic         s0_bvalid_o,
  input  logic         s0_bready_i,
  output logic [8:0]   s0_bid_o,
  output logic [1:0]   s0_bresp_o,
  input  logic         s0_arvalid_i,
  output logic         s0_arready_o,
  input  logic [8:0]   s0_arid_i,
  input  logic [63:0]  s0_araddr_i,
  input  logic [7:0]   s0_arlen_i,
  output logic         s0_rvalid_o,
  input  logic         s0_rready_i,
  output logic [8:0]   s0_rid_o,
  output logic [511:0] s0_rdata_o,
  output logic [1:0]   s0_rresp_o,
  output logic         s0_rlast_o,
  // requester 1
  input  logic         s1_awvalid_i,
  output logic         s1_awready_o,
  input  logic [8:0]   s1_awid_i,
  input  logic [63:0]  s1_awaddr_i,
  input  logic [7:0]   s1_awlen_i,
  input  logic         s1_wvalid_i,
  output logic         s1_wready_o,
  input  logic [511:0] s1_wdata_i,
  input  logic [63:0]  s1_wstrb_i,
  input  logic         s1_wlast_i,
  output logic         s1_bvalid_o,
  input  logic         s1_bready_i,
  output logic [8:0]   s1_bid_o,
  output logic [1:0]   s1_bresp_o,
  input  logic         s1_arvalid_i,
  output logic         s1_arready_o,
  input  logic [8:0]   s1_arid_i,
  input  logic [63:0]  s1_araddr_i,
  input  logic [7:0]   s1_arlen_i,
  output logic         s1_rvalid_o,
  input  logic         s1_rready_i,
  output logic [8:0]   s1_rid_o,
  output logic [511:0] s1_rdata_o,
  output logic [1:0]   s1_rresp_o,
  output logic         s1_rlast_o,
  // shared PCIM port
  output logic         cl_sh_pcim_awvalid_o,
  input  logic         cl_sh_pcim_awready_i,
  output logic [15:0]  cl_sh_pcim_awid_o,
  output logic [63:0]  cl_sh_pcim_awaddr_o,
  output logic [7:0]   cl_sh_pcim_awlen_o,
  output logic [2:0]   cl_sh_pcim_awsize_o,
  output logic         cl_sh_pcim_wvalid_o,
  input  logic         cl_sh_pcim_wready_i,
  output logic [511:0] cl_sh_pcim_wdata_o,
  output logic [63:0]  cl_sh_pcim_wstrb_o,
  output logic         cl_sh_pcim_wlast_o,
  input  logic         cl_sh_pcim_bvalid_i,
  output logic         cl_sh_pcim_bready_o,
  input  logic [15:0]  cl_sh_pcim_bid_i,
  input  logic [1:0]   cl_sh_pcim_bresp_i,
  output logic         cl_sh_pcim_arvalid_o,
  input  logic         cl_sh_pcim_arready_i,
  output logic [15:0]  cl_sh_pcim_arid_o,
  output logic [63:0]  cl_sh_pcim_araddr_o,
  output logic [7:0]   cl_sh_pcim_arlen_o,
  output logic [2:0]   cl_sh_pcim_arsize_o,
  input  logic         cl_sh_pcim_rvalid_i,
  output logic         cl_sh_pcim_rready_o,
  input  logic [15:0]  cl_sh_pcim_rid_i,
  input  logic [511:0] cl_sh_pcim_rdata_i,
  input  logic [1:0]   cl_sh_pcim_rresp_i,
  input  logic         cl_sh_pcim_rlast_i,
  // status
  output logic [7:0]   wr_out_cnt,
  output logic [7:0]   rd_out_cnt
);

  typedef enum logic [1:0] {StIdle = 2'd0, StGnt0 = 2'd1, StGnt1 = 2'd2} arb_state_e;

  localparam int unsigned PtrW     = (WORD_FIFO_DEPTH > 1) ? $clog2(WORD_FIFO_DEPTH) : 1;
  localparam logic [7:0]  MaxOut   = 8'(MAX_OUTSTANDING);
  localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(WORD_FIFO_DEPTH);

  arb_state_e aw_state_q, aw_state_d;
  arb_state_e ar_state_q, ar_state_d;
  logic       aw_last_q, aw_last_d;
  logic       ar_last_q, ar_last_d;
  logic       init_q, init_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;

  logic [WORD_FIFO_DEPTH-1:0] fifo_mem_q, fifo_mem_d;
  logic [PtrW-1:0]            fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic [PtrW-1:0]            fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [PtrW:0]              fifo_cnt_q, fifo_cnt_d;

  logic aw_blocked, ar_blocked;
  logic aw_hs, ar_hs, aw_src, ar_src;
  logic fifo_empty, fifo_full;
  logic w_active, w_src, w_pop;
  logic b_dst, r_dst, b_hs, r_hs_last;
  logic unused_id_bits;

  assign unused_id_bits = ^{cl_sh_pcim_bid_i[15:10], cl_sh_pcim_rid_i[15:10]};

  // State registers; init_q holds off the first grant until one edge after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_state_q    <= StIdle;
      ar_state_q    <= StIdle;
      aw_last_q     <= 1'b1;
      ar_last_q     <= 1'b1;
      init_q        <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      fifo_mem_q    <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      aw_state_q    <= aw_state_d;
      ar_state_q    <= ar_state_d;
      aw_last_q     <= aw_last_d;
      ar_last_q     <= ar_last_d;
      init_q        <= init_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      fifo_mem_q    <= fifo_mem_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  assign init_d     = 1'b1;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign aw_blocked = !init_q || (wr_cnt_q == MaxOut) || fifo_full;
  assign ar_blocked = !init_q || (rd_cnt_q == MaxOut);

  // AW grant FSM: round-robin from idle, release on the PCIM handshake.
  always_comb begin
    aw_state_d = aw_state_q;
    aw_last_d  = aw_last_q;
    case (aw_state_q)
      StIdle: begin
        if (!aw_blocked) begin
          if (s0_awvalid_i && s1_awvalid_i) aw_state_d = aw_last_q ? StGnt0 : StGnt1;
          else if (s0_awvalid_i)            aw_state_d = StGnt0;
          else if (s1_awvalid_i)            aw_state_d = StGnt1;
        end
      end
      StGnt0: if (aw_hs) begin aw_state_d = StIdle; aw_last_d = 1'b0; end
      StGnt1: if (aw_hs) begin aw_state_d = StIdle; aw_last_d = 1'b1; end
      default: aw_state_d = StIdle;
    endcase
  end

  // AR grant FSM, independent of AW.
  always_comb begin
    ar_state_d = ar_state_q;
    ar_last_d  = ar_last_q;
    case (ar_state_q)
      StIdle: begin
        if (!ar_blocked) begin
          if (s0_arvalid_i && s1_arvalid_i) ar_state_d = ar_last_q ? StGnt0 : StGnt1;
          else if (s0_arvalid_i)            ar_state_d = StGnt0;
          else if (s1_arvalid_i)            ar_state_d = StGnt1;
        end
      end
      StGnt0: if (ar_hs) begin ar_state_d = StIdle; ar_last_d = 1'b0; end
      StGnt1: if (ar_hs) begin ar_state_d = StIdle; ar_last_d = 1'b1; end
      default: ar_state_d = StIdle;
    endcase
  end

  // Address channel muxes driven purely from the registered grant.
  always_comb begin
    aw_src               = (aw_state_q == StGnt1);
    cl_sh_pcim_awvalid_o = ((aw_state_q == StGnt0) && s0_awvalid_i) ||
                           ((aw_state_q == StGnt1) && s1_awvalid_i);
    cl_sh_pcim_awid_o    = {6'b0, aw_src, aw_src ? s1_awid_i : s0_awid_i};
    cl_sh_pcim_awaddr_o  = aw_src ? s1_awaddr_i : s0_awaddr_i;
    cl_sh_pcim_awlen_o   = aw_src ? s1_awlen_i : s0_awlen_i;
    cl_sh_pcim_awsize_o  = 3'h6;
    s0_awready_o         = (aw_state_q == StGnt0) && cl_sh_pcim_awready_i;
    s1_awready_o         = (aw_state_q == StGnt1) && cl_sh_pcim_awready_i;
    aw_hs                = cl_sh_pcim_awvalid_o && cl_sh_pcim_awready_i;

    ar_src               = (ar_state_q == StGnt1);
    cl_sh_pcim_arvalid_o = ((ar_state_q == StGnt0) && s0_arvalid_i) ||
                           ((ar_state_q == StGnt1) && s1_arvalid_i);
    cl_sh_pcim_arid_o    = {6'b0, ar_src, ar_src ? s1_arid_i : s0_arid_i};
    cl_sh_pcim_araddr_o  = ar_src ? s1_araddr_i : s0_araddr_i;
    cl_sh_pcim_arlen_o   = ar_src ? s1_arlen_i : s0_arlen_i;
    cl_sh_pcim_arsize_o  = 3'h6;
    s0_arready_o         = (ar_state_q == StGnt0) && cl_sh_pcim_arready_i;
    s1_arready_o         = (ar_state_q == StGnt1) && cl_sh_pcim_arready_i;
    ar_hs                = cl_sh_pcim_arvalid_o && cl_sh_pcim_arready_i;
  end

  // W routing; with an empty FIFO the AW being accepted this cycle bypasses straight to the head.
  always_comb begin
    w_active            = !fifo_empty || aw_hs;
    w_src               = fifo_empty ? aw_src : fifo_mem_q[fifo_rd_ptr_q];
    cl_sh_pcim_wvalid_o = w_active && (w_src ? s1_wvalid_i : s0_wvalid_i);
    cl_sh_pcim_wdata_o  = w_src ? s1_wdata_i : s0_wdata_i;
    cl_sh_pcim_wstrb_o  = w_src ? s1_wstrb_i : s0_wstrb_i;
    cl_sh_pcim_wlast_o  = w_src ? s1_wlast_i : s0_wlast_i;
    s0_wready_o         = w_active && !w_src && cl_sh_pcim_wready_i;
    s1_wready_o         = w_active && w_src && cl_sh_pcim_wready_i;
    w_pop = cl_sh_pcim_wvalid_o && cl_sh_pcim_wready_i && cl_sh_pcim_wlast_o;
  end

  // W-order FIFO: push source on AW handshake, pop on last W beat.
  always_comb begin
    fifo_mem_d    = fifo_mem_q;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    if (aw_hs) begin
      fifo_mem_d[fifo_wr_ptr_q] = aw_src;
      fifo_wr_ptr_d             = fifo_wr_ptr_q + 1'b1;
    end
    if (w_pop) fifo_rd_ptr_d = fifo_rd_ptr_q + 1'b1;
    if (aw_hs && !w_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!aw_hs && w_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  // B and R return routing by id bit 9.
  always_comb begin
    b_dst               = cl_sh_pcim_bid_i[9];
    s0_bvalid_o         = cl_sh_pcim_bvalid_i && !b_dst;
    s1_bvalid_o         = cl_sh_pcim_bvalid_i && b_dst;
    s0_bid_o            = cl_sh_pcim_bid_i[8:0];
    s1_bid_o            = cl_sh_pcim_bid_i[8:0];
    s0_bresp_o          = cl_sh_pcim_bresp_i;
    s1_bresp_o          = cl_sh_pcim_bresp_i;
    cl_sh_pcim_bready_o = b_dst ? s1_bready_i : s0_bready_i;
    b_hs                = cl_sh_pcim_bvalid_i && cl_sh_pcim_bready_o;

    r_dst               = cl_sh_pcim_rid_i[9];
    s0_rvalid_o         = cl_sh_pcim_rvalid_i && !r_dst;
    s1_rvalid_o         = cl_sh_pcim_rvalid_i && r_dst;
    s0_rid_o            = cl_sh_pcim_rid_i[8:0];
    s1_rid_o            = cl_sh_pcim_rid_i[8:0];
    s0_rdata_o          = cl_sh_pcim_rdata_i;
    s1_rdata_o          = cl_sh_pcim_rdata_i;
    s0_rresp_o          = cl_sh_pcim_rresp_i;
    s1_rresp_o          = cl_sh_pcim_rresp_i;
    s0_rlast_o          = cl_sh_pcim_rlast_i;
    s1_rlast_o          = cl_sh_pcim_rlast_i;
    cl_sh_pcim_rready_o = r_dst ? s1_rready_i : s0_rready_i;
    r_hs_last           = cl_sh_pcim_rvalid_i && cl_sh_pcim_rready_o && cl_sh_pcim_rlast_i;
  end

  // Outstanding counters; an unsolicited response at zero saturates.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs)                         wr_cnt_d = wr_cnt_q + 8'd1;
    else if (!aw_hs && b_hs && wr_cnt_q != '0)  wr_cnt_d = wr_cnt_q - 8'd1;
    if (ar_hs && !r_hs_last)                        rd_cnt_d = rd_cnt_q + 8'd1;
    else if (!ar_hs && r_hs_last && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 8'd1;
  end

  assign wr_out_cnt = wr_cnt_q;
  assign rd_out_cnt = rd_cnt_q;

endmodule

// File: tb/tb_cl_pcim_arb.sv
// Directed bench for cl_pcim_arb: a routing vector table plus hand-written arbitration sequences.
module tb_cl_pcim_arb;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic         s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [8:0]   s0_awid, s1_awid, s0_arid, s1_arid;
  logic [63:0]  s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
  logic [7:0]   s0_awlen, s1_awlen, s0_arlen, s1_arlen;
  logic         s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
  logic [511:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata;
  logic [63:0]  s0_wstrb, s1_wstrb;
  logic         s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic [8:0]   s0_bid, s1_bid, s0_rid, s1_rid;
  logic [1:0]   s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic         s0_arvalid, s0_arready, s1_arvalid, s1_arready;
  logic         s0_rvalid, s0_rready, s0_rlast, s1_rvalid, s1_rready, s1_rlast;
  logic         m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [15:0]  m_awid, m_arid, m_bid, m_rid;
  logic [63:0]  m_awaddr, m_araddr, m_wstrb;
  logic [7:0]   m_awlen, m_arlen;
  logic [2:0]   m_awsize, m_arsize;
  logic [511:0] m_wdata, m_rdata;
  logic         m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [1:0]   m_bresp, m_rresp;
  logic [7:0]   wr_out_cnt, rd_out_cnt;

  cl_pcim_arb #(.MAX_OUTSTANDING(2), .WORD_FIFO_DEPTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awvalid_i(s0_awvalid), .s0_awready_o(s0_awready), .s0_awid_i(s0_awid),
    .s0_awaddr_i(s0_awaddr), .s0_awlen_i(s0_awlen),
    .s0_wvalid_i(s0_wvalid), .s0_wready_o(s0_wready), .s0_wdata_i(s0_wdata),
    .s0_wstrb_i(s0_wstrb), .s0_wlast_i(s0_wlast),
    .s0_bvalid_o(s0_bvalid), .s0_bready_i(s0_bready), .s0_bid_o(s0_bid), .s0_bresp_o(s0_bresp),
    .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_arid_i(s0_arid),
    .s0_araddr_i(s0_araddr), .s0_arlen_i(s0_arlen),
    .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rid_o(s0_rid), .s0_rdata_o(s0_rdata),
    .s0_rresp_o(s0_rresp), .s0_rlast_o(s0_rlast),
    .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready), .s1_awid_i(s1_awid),
    .s1_awaddr_i(s1_awaddr), .s1_awlen_i(s1_awlen),
    .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready), .s1_wdata_i(s1_wdata),
    .s1_wstrb_i(s1_wstrb), .s1_wlast_i(s1_wlast),
    .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready), .s1_bid_o(s1_bid), .s1_bresp_o(s1_bresp),
    .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_arid_i(s1_arid),
    .s1_araddr_i(s1_araddr), .s1_arlen_i(s1_arlen),
    .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rid_o(s1_rid), .s1_rdata_o(s1_rdata),
    .s1_rresp_o(s1_rresp), .s1_rlast_o(s1_rlast),
    .cl_sh_pcim_awvalid_o(m_awvalid), .cl_sh_pcim_awready_i(m_awready),
    .cl_sh_pcim_awid_o(m_awid), .cl_sh_pcim_awaddr_o(m_awaddr), .cl_sh_pcim_awlen_o(m_awlen),
    .cl_sh_pcim_awsize_o(m_awsize),
    .cl_sh_pcim_wvalid_o(m_wvalid), .cl_sh_pcim_wready_i(m_wready),
    .cl_sh_pcim_wdata_o(m_wdata), .cl_sh_pcim_wstrb_o(m_wstrb), .cl_sh_pcim_wlast_o(m_wlast),
    .cl_sh_pcim_bvalid_i(m_bvalid), .cl_sh_pcim_bready_o(m_bready),
    .cl_sh_pcim_bid_i(m_bid), .cl_sh_pcim_bresp_i(m_bresp),
    .cl_sh_pcim_arvalid_o(m_arvalid), .cl_sh_pcim_arready_i(m_arready),
    .cl_sh_pcim_arid_o(m_arid), .cl_sh_pcim_araddr_o(m_araddr), .cl_sh_pcim_arlen_o(m_arlen),
    .cl_sh_pcim_arsize_o(m_arsize),
    .cl_sh_pcim_rvalid_i(m_rvalid), .cl_sh_pcim_rready_o(m_rready),
    .cl_sh_pcim_rid_i(m_rid), .cl_sh_pcim_rdata_i(m_rdata), .cl_sh_pcim_rresp_i(m_rresp),
    .cl_sh_pcim_rlast_i(m_rlast),
    .wr_out_cnt(wr_out_cnt), .rd_out_cnt(rd_out_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  typedef struct {
    logic        bvalid;
    logic [15:0] bid;
    logic        b0rdy, b1rdy;
    logic        rvalid;
    logic [15:0] rid;
    logic        r0rdy, r1rdy;
    logic        e_s0bv, e_s1bv;
    logic [8:0]  e_bid;
    logic        e_bready;
    logic        e_s0rv, e_s1rv;
    logic [8:0]  e_rid;
    logic        e_rready;
  } route_vec_t;

  route_vec_t vecs[5];

  initial begin
    vecs[0] = '{1, 16'h0012, 1, 0, 1, 16'h0234, 0, 1, 1, 0, 9'h012, 1, 0, 1, 9'h034, 1};
    vecs[1] = '{1, 16'hFC12, 0, 1, 1, 16'hFE34, 1, 0, 1, 0, 9'h012, 0, 0, 1, 9'h034, 0};
    vecs[2] = '{1, 16'h03FF, 0, 1, 1, 16'h01AA, 1, 0, 0, 1, 9'h1FF, 1, 1, 0, 9'h1AA, 1};
    vecs[3] = '{0, 16'h0200, 1, 1, 0, 16'h0000, 0, 1, 0, 0, 9'h000, 1, 0, 0, 9'h000, 0};
    vecs[4] = '{1, 16'hFE00, 1, 0, 1, 16'h7C00, 1, 1, 0, 1, 9'h000, 0, 1, 0, 9'h000, 1};

    aresetn = 1'b0;
    s0_awvalid = 1; s1_awvalid = 1; s0_awid = 9'd5; s1_awid = 9'd7;
    s0_awaddr = 64'h1000; s1_awaddr = 64'h2000; s0_awlen = 0; s1_awlen = 0;
    s0_wvalid = 1; s1_wvalid = 1; s0_wlast = 1; s1_wlast = 1;
    s0_wdata = {8{64'hA0A0}}; s1_wdata = {8{64'hB1B1}}; s0_wstrb = '1; s1_wstrb = '1;
    s0_bready = 1; s1_bready = 1; s0_rready = 1; s1_rready = 1;
    s0_arvalid = 1; s1_arvalid = 0; s0_arid = 9'd2; s1_arid = 9'd1;
    s0_araddr = 64'h4000; s1_araddr = 64'h3000; s0_arlen = 0; s1_arlen = 1;
    m_awready = 1; m_wready = 1; m_arready = 0;
    m_bvalid = 0; m_bid = '0; m_bresp = '0;
    m_rvalid = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0;

    // Reset state with requests pending.
    repeat (2) tick();
    #2;
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_s0_awready", s0_awready, 0);
    chk("rst_s1_awready", s1_awready, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_s0_wready", s0_wready, 0);
    chk("rst_s1_wready", s1_wready, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_wr_cnt", wr_out_cnt, 0);
    chk("rst_rd_cnt", rd_out_cnt, 0);

    // Release; no grant before the second edge, then s0 first and alternating.
    aresetn = 1'b1; s0_arvalid = 0;
    #1;
    chk("rel_awvalid", m_awvalid, 0);
    tick(); #2;
    chk("edge1_awvalid", m_awvalid, 0);
    chk("edge1_s0_awready", s0_awready, 0);
    tick(); #2;
    chk("g1_awvalid", m_awvalid, 1);
    chk("g1_awid", m_awid, 16'h0005);
    chk("g1_awaddr", m_awaddr, 64'h1000);
    chk("g1_awsize", m_awsize, 3'h6);
    chk("g1_s0_awready", s0_awready, 1);
    chk("g1_s1_awready", s1_awready, 0);
    chk("g1_wvalid", m_wvalid, 1);
    chk("g1_wdata", m_wdata[63:0], 64'hA0A0);
    chk("g1_s0_wready", s0_wready, 1);
    chk("g1_s1_wready", s1_wready, 0);
    tick(); #2;
    chk("idle1_awvalid", m_awvalid, 0);
    chk("idle1_s0_awready", s0_awready, 0);
    chk("idle1_s1_awready", s1_awready, 0);
    chk("idle1_wvalid", m_wvalid, 0);
    chk("idle1_wr_cnt", wr_out_cnt, 1);
    tick(); #2;
    chk("g2_awid", m_awid, 16'h0207);
    chk("g2_s1_awready", s1_awready, 1);
    chk("g2_s0_awready", s0_awready, 0);
    chk("g2_wdata", m_wdata[63:0], 64'hB1B1);
    chk("g2_s1_wready", s1_wready, 1);
    tick(); #2;
    chk("g2_wr_cnt", wr_out_cnt, 2);
    tick(); #2;
    chk("full_awvalid", m_awvalid, 0);
    chk("full_s0_awready", s0_awready, 0);
    chk("full_wr_cnt", wr_out_cnt, 2);

    // One B to s0 frees a slot; the next AW goes to s0.
    m_bvalid = 1; m_bid = 16'h0003; m_bresp = 2'b10;
    #1;
    chk("b1_s0_bvalid", s0_bvalid, 1);
    chk("b1_s0_bid", s0_bid, 9'd3);
    chk("b1_s0_bresp", s0_bresp, 2'b10);
    chk("b1_s1_bvalid", s1_bvalid, 0);
    chk("b1_bready", m_bready, 1);
    tick(); m_bvalid = 0; #2;
    chk("b1_wr_cnt", wr_out_cnt, 1);
    chk("b1_awvalid", m_awvalid, 0);
    tick(); #2;
    chk("g3_awid", m_awid, 16'h0005);
    tick(); #2;
    chk("g3_wr_cnt", wr_out_cnt, 2);

    // Same-cycle AW and B handshake leaves the count unchanged.
    m_bvalid = 1; m_bid = 16'h0200;
    tick(); m_bvalid = 0; #2;
    chk("b2_wr_cnt", wr_out_cnt, 1);
    tick(); #2;
    chk("g4_awid", m_awid, 16'h0207);
    m_bvalid = 1; m_bid = 16'h0200;
    #1;
    chk("b3_s1_bvalid", s1_bvalid, 1);
    chk("b3_s0_bvalid", s0_bvalid, 0);
    tick();
    m_bvalid = 0; s0_awvalid = 0; s1_awvalid = 0; s0_wvalid = 0; s1_wvalid = 0;
    #2;
    chk("aw_b_same_wr_cnt", wr_out_cnt, 1);
    m_bvalid = 1; m_bid = 16'h0000;
    tick(); #2;
    chk("drain_wr_cnt", wr_out_cnt, 0);
    chk("unsol_s0_bvalid", s0_bvalid, 1);
    tick(); m_bvalid = 0; #2;
    chk("sat_wr_cnt", wr_out_cnt, 0);

    // W ordering: s1 len=3 then s0 len=0; s0 W waits behind s1's four beats.
    s1_awvalid = 1; s1_awlen = 8'd3; s1_awid = 9'd9;
    s0_wvalid = 1; s0_wlast = 1; s1_wvalid = 0;
    tick(); #2;
    chk("wo_s1_awready", s1_awready, 1);
    chk("wo_wvalid0", m_wvalid, 0);
    chk("wo_s0_wready0", s0_wready, 0);
    tick();
    s1_awvalid = 0; s0_awvalid = 1; s0_awlen = 0; s0_awid = 9'd4;
    #2;
    chk("wo_s0_wready1", s0_wready, 0);
    tick(); #2;
    chk("wo_s0_awready", s0_awready, 1);
    chk("wo_awid", m_awid, 16'h0004);
    chk("wo_s0_wready2", s0_wready, 0);
    tick();
    s0_awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      s1_wvalid = 1; s1_wlast = (b == 3); s1_wdata = {8{64'hB000 + 64'(b)}};
      #2;
      chk("wo_beat_wvalid", m_wvalid, 1);
      chk("wo_beat_wdata", m_wdata[63:0], 64'hB000 + 64'(b));
      chk("wo_beat_wlast", m_wlast, (b == 3));
      chk("wo_beat_s1_wready", s1_wready, 1);
      chk("wo_beat_s0_wready", s0_wready, 0);
      tick();
    end
    s1_wvalid = 0;
    #2;
    chk("wo_s0_wready3", s0_wready, 1);
    chk("wo_s0_wdata", m_wdata[63:0], 64'hA0A0);
    chk("wo_s0_wlast", m_wlast, 1);
    tick(); #2;
    chk("wo_empty_wvalid", m_wvalid, 0);
    chk("wo_empty_s0_wready", s0_wready, 0);
    s0_wvalid = 0;
    m_bvalid = 1; m_bid = 16'h0209;
    repeat (2) tick();
    m_bvalid = 0; #2;
    chk("wo_wr_cnt", wr_out_cnt, 0);

    // Read: s1 AR len=1, two R beats back with rid=0x201.
    s1_arvalid = 1; m_arready = 1;
    tick(); #2;
    chk("ar_arvalid", m_arvalid, 1);
    chk("ar_arid", m_arid, 16'h0201);
    chk("ar_arlen", m_arlen, 8'd1);
    chk("ar_arsize", m_arsize, 3'h6);
    chk("ar_araddr", m_araddr, 64'h3000);
    chk("ar_s1_arready", s1_arready, 1);
    chk("ar_s0_arready", s0_arready, 0);
    tick(); s1_arvalid = 0; #2;
    chk("ar_rd_cnt", rd_out_cnt, 1);
    chk("ar_idle_arvalid", m_arvalid, 0);
    m_rvalid = 1; m_rid = 16'h0201; m_rlast = 0; m_rdata = {8{64'hD0D0}};
    #2;
    chk("r1_s1_rvalid", s1_rvalid, 1);
    chk("r1_s1_rid", s1_rid, 9'd1);
    chk("r1_s1_rdata", s1_rdata[63:0], 64'hD0D0);
    chk("r1_s0_rvalid", s0_rvalid, 0);
    chk("r1_rready", m_rready, 1);
    tick(); m_rlast = 1; #2;
    chk("r1_rd_cnt", rd_out_cnt, 1);
    chk("r2_s1_rlast", s1_rlast, 1);
    chk("r2_s0_rvalid", s0_rvalid, 0);
    tick(); m_rvalid = 0; m_rlast = 0; #2;
    chk("r2_rd_cnt", rd_out_cnt, 0);

    // Routing vector table; counters sit at zero throughout.
    for (int i = 0; i < 5; i++) begin
      m_bvalid = vecs[i].bvalid; m_bid = vecs[i].bid;
      s0_bready = vecs[i].b0rdy; s1_bready = vecs[i].b1rdy;
      m_rvalid = vecs[i].rvalid; m_rid = vecs[i].rid; m_rlast = 1'b1;
      s0_rready = vecs[i].r0rdy; s1_rready = vecs[i].r1rdy;
      #2;
      chk($sformatf("vec%0d_s0_bvalid", i), s0_bvalid, vecs[i].e_s0bv);
      chk($sformatf("vec%0d_s1_bvalid", i), s1_bvalid, vecs[i].e_s1bv);
      chk($sformatf("vec%0d_bid", i), s1_bid, vecs[i].e_bid);
      chk($sformatf("vec%0d_bready", i), m_bready, vecs[i].e_bready);
      chk($sformatf("vec%0d_s0_rvalid", i), s0_rvalid, vecs[i].e_s0rv);
      chk($sformatf("vec%0d_s1_rvalid", i), s1_rvalid, vecs[i].e_s1rv);
      chk($sformatf("vec%0d_rid", i), s0_rid, vecs[i].e_rid);
      chk($sformatf("vec%0d_rready", i), m_rready, vecs[i].e_rready);
      tick();
    end
    m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
    s0_bready = 1; s1_bready = 1; s0_rready = 1; s1_rready = 1;
    #2;
    chk("vec_sat_wr_cnt", wr_out_cnt, 0);
    chk("vec_sat_rd_cnt", rd_out_cnt, 0);

    // Reset in the middle of an s0 W burst.
    s0_awvalid = 1; s0_awlen = 8'd3; s0_awid = 9'd5; s0_wvalid = 1; s0_wlast = 0;
    s0_wdata = {8{64'hA0A0}};
    tick(); #2;
    chk("mb_s0_awready", s0_awready, 1);
    tick();
    s1_awvalid = 1; s0_arvalid = 1;
    #2;
    chk("mb_wr_cnt", wr_out_cnt, 1);
    chk("mb_s0_wready", s0_wready, 1);
    aresetn = 1'b0;
    #1;
    chk("mbrst_wr_cnt", wr_out_cnt, 0);
    chk("mbrst_rd_cnt", rd_out_cnt, 0);
    chk("mbrst_wvalid", m_wvalid, 0);
    chk("mbrst_s0_wready", s0_wready, 0);
    chk("mbrst_awvalid", m_awvalid, 0);
    chk("mbrst_s0_awready", s0_awready, 0);
    chk("mbrst_s1_awready", s1_awready, 0);
    chk("mbrst_arvalid", m_arvalid, 0);
    chk("mbrst_s0_arready", s0_arready, 0);
    tick(); #2;
    aresetn = 1'b1;
    #1;
    chk("mbrel_wvalid", m_wvalid, 0);
    tick(); #2;
    chk("mbrel_edge1_awvalid", m_awvalid, 0);
    tick(); #2;
    chk("mbrel_awid", m_awid, 16'h0005);
    chk("mbrel_s0_awready", s0_awready, 1);
    chk("mbrel_s1_awready", s1_awready, 0);
    chk("mbrel_arid", m_arid, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
